// File: rtl/proj_sorter_reader_if.sv
// Index stream from the sorter reader toward the extender.
// The master drives the index beats; the slave returns ready.
interface proj_sorter_reader_if #(
    parameter int INDICE_LEN = 8
);
    logic [INDICE_LEN-1:0] out_idx;
    logic                  out_valid;
    logic                  out_last;
    logic                  in_ready;

    modport master (
        output out_idx,
        output out_valid,
        output out_last,
        input  in_ready
    );

    modport slave (
        input  out_idx,
        input  out_valid,
        input  out_last,
        output in_ready
    );
endinterface

// File: rtl/proj_sorter_reader.sv
// Snapshots the sorter's k-smallest index array on frame_done and streams it one index per beat.
// Latency: first beat one cycle after the accepted frame_done edge, then one beat per cycle.
// Backpressure: beats hold while ready is low; frames arriving mid-stream are dropped and counted.
module proj_sorter_reader #(
    parameter int INDICES_COUNT = 4,
    parameter int INDICE_LEN    = 8,
    parameter int CNT_W         = $clog2(INDICES_COUNT + 1),
    parameter int DROP_W        = 8
) (
    input  logic                                    in_clk,
    input  logic                                    in_rst_n,
    input  logic [INDICES_COUNT-1:0][INDICE_LEN-1:0] in_smallest_idx,
    input  logic [CNT_W-1:0]                        in_valid_count,
    input  logic                                    in_frame_done,
    proj_sorter_reader_if.master                    stream,
    output logic                                    out_busy,
    output logic [DROP_W-1:0]                       out_drop_cnt
);
    localparam int IDX_W = (INDICES_COUNT > 1) ? $clog2(INDICES_COUNT) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    typedef logic [INDICES_COUNT-1:0][INDICE_LEN-1:0] snap_t;

    state_t                state_q,  state_nxt;
    snap_t                 snap_q,   snap_nxt;
    logic [CNT_W-1:0]      count_q,  count_nxt;
    logic [CNT_W-1:0]      ptr_q,    ptr_nxt;
    logic [INDICE_LEN-1:0] idx_q,    idx_nxt;
    logic                  valid_q,  valid_nxt;
    logic                  last_q,   last_nxt;
    logic                  busy_q,   busy_nxt;
    logic [DROP_W-1:0]     drop_q,   drop_nxt;

    logic                  hs;
    logic                  accept;
    logic [CNT_W-1:0]      cnt_clamp;
    logic [CNT_W-1:0]      ptr_inc;

    assign hs        = valid_q & stream.in_ready;
    assign cnt_clamp = (in_valid_count > CNT_W'(INDICES_COUNT)) ? CNT_W'(INDICES_COUNT)
                                                                : in_valid_count;
    assign ptr_inc   = ptr_q + CNT_W'(1);

    // A frame is taken when idle, or on the very edge the final beat is accepted (no bubble).
    assign accept = in_frame_done && ((state_q == IDLE) || (hs && last_q));

    always_comb begin
        state_nxt = state_q;
        snap_nxt  = snap_q;
        count_nxt = count_q;
        ptr_nxt   = ptr_q;
        idx_nxt   = idx_q;
        valid_nxt = valid_q;
        last_nxt  = last_q;
        busy_nxt  = busy_q;
        drop_nxt  = drop_q;

        if (accept) begin
            snap_nxt  = in_smallest_idx;
            count_nxt = cnt_clamp;
            ptr_nxt   = '0;
            if (cnt_clamp != '0) begin
                state_nxt = SEND;
                idx_nxt   = in_smallest_idx[0];
                valid_nxt = 1'b1;
                busy_nxt  = 1'b1;
                last_nxt  = (cnt_clamp == CNT_W'(1));
            end else begin
                state_nxt = IDLE;
                valid_nxt = 1'b0;
                busy_nxt  = 1'b0;
                last_nxt  = 1'b0;
            end
        end else if (state_q == SEND) begin
            if (in_frame_done && (drop_q != {DROP_W{1'b1}})) begin
                drop_nxt = drop_q + DROP_W'(1);
            end
            if (hs) begin
                if (last_q) begin
                    state_nxt = IDLE;
                    valid_nxt = 1'b0;
                    busy_nxt  = 1'b0;
                    last_nxt  = 1'b0;
                end else begin
                    ptr_nxt  = ptr_inc;
                    idx_nxt  = snap_q[ptr_inc[IDX_W-1:0]];
                    last_nxt = (ptr_inc == (count_q - CNT_W'(1)));
                end
            end
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q <= IDLE;
            snap_q  <= '0;
            count_q <= '0;
            ptr_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_nxt;
            snap_q  <= snap_nxt;
            count_q <= count_nxt;
            ptr_q   <= ptr_nxt;
            idx_q   <= idx_nxt;
            valid_q <= valid_nxt;
            last_q  <= last_nxt;
            busy_q  <= busy_nxt;
            drop_q  <= drop_nxt;
        end
    end

    assign stream.out_idx   = idx_q;
    assign stream.out_valid = valid_q;
    assign stream.out_last  = last_q;
    assign out_busy         = busy_q;
    assign out_drop_cnt     = drop_q;
endmodule

// File: tb/tb_proj_sorter_reader.sv
// Directed bench for proj_sorter_reader with INDICES_COUNT=4, INDICE_LEN=8.
module tb_proj_sorter_reader;
    localparam int N  = 4;
    localparam int IL = 8;
    localparam int CW = 3;

    logic                    in_clk;
    logic                    in_rst_n;
    logic [N-1:0][IL-1:0]    in_smallest_idx;
    logic [CW-1:0]           in_valid_count;
    logic                    in_frame_done;
    logic                    out_busy;
    logic [7:0]              out_drop_cnt;

    int n_chk;
    int n_pass;

    logic [N-1:0][IL-1:0] arr_a;
    logic [N-1:0][IL-1:0] arr_b;
    logic [N-1:0][IL-1:0] arr_junk;

    proj_sorter_reader_if #(.INDICE_LEN(IL)) stream_if ();

    proj_sorter_reader #(
        .INDICES_COUNT (N),
        .INDICE_LEN    (IL),
        .CNT_W         (CW),
        .DROP_W        (8)
    ) dut (
        .in_clk          (in_clk),
        .in_rst_n        (in_rst_n),
        .in_smallest_idx (in_smallest_idx),
        .in_valid_count  (in_valid_count),
        .in_frame_done   (in_frame_done),
        .stream          (stream_if),
        .out_busy        (out_busy),
        .out_drop_cnt    (out_drop_cnt)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge in_clk);
        #1;
    endtask

    task automatic pulse_frame();
        in_frame_done = 1'b1;
        step();
        in_frame_done = 1'b0;
    endtask

    // Checks the beat currently presented, accepts it with ready high, then checks the stream ends.
    task automatic expect_beats(input string tag, input logic [N-1:0][IL-1:0] exp_arr, input int n);
        for (int b = 0; b < n; b++) begin
            chk({tag, "_valid"}, 32'(stream_if.out_valid), 32'd1);
            chk({tag, "_idx"},   32'(stream_if.out_idx),   32'(exp_arr[b]));
            chk({tag, "_last"},  32'(stream_if.out_last),  32'(b == n - 1));
            chk({tag, "_busy"},  32'(out_busy),            32'd1);
            step();
        end
        chk({tag, "_end_valid"}, 32'(stream_if.out_valid), 32'd0);
        chk({tag, "_end_busy"},  32'(out_busy),            32'd0);
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        arr_a    = {8'h20, 8'h11, 8'h0A, 8'h03};
        arr_b    = {8'h00, 8'h00, 8'h66, 8'h55};
        arr_junk = {8'hEE, 8'hDD, 8'hCC, 8'hBB};

        in_rst_n           = 1'b0;
        in_frame_done      = 1'b0;
        in_smallest_idx    = '0;
        in_valid_count     = '0;
        stream_if.in_ready = 1'b1;
        repeat (3) step();

        chk("rst_valid", 32'(stream_if.out_valid), 32'd0);
        chk("rst_last",  32'(stream_if.out_last),  32'd0);
        chk("rst_idx",   32'(stream_if.out_idx),   32'd0);
        chk("rst_busy",  32'(out_busy),            32'd0);
        chk("rst_drop",  32'(out_drop_cnt),        32'd0);

        in_rst_n = 1'b1;
        repeat (2) step();

        // Basic stream; inputs change after capture and must not leak into the stream.
        in_smallest_idx = arr_a;
        in_valid_count  = 3'd4;
        pulse_frame();
        in_smallest_idx = arr_junk;
        in_valid_count  = 3'd1;
        expect_beats("basic", arr_a, 4);

        // Backpressure: ready low for two edges while 0x0A is presented.
        in_smallest_idx = arr_a;
        in_valid_count  = 3'd4;
        pulse_frame();
        chk("bp_b0", 32'(stream_if.out_idx), 32'h03);
        step();
        chk("bp_b1", 32'(stream_if.out_idx), 32'h0A);
        stream_if.in_ready = 1'b0;
        step();
        chk("bp_hold1_idx",   32'(stream_if.out_idx),   32'h0A);
        chk("bp_hold1_valid", 32'(stream_if.out_valid), 32'd1);
        step();
        chk("bp_hold2_idx",   32'(stream_if.out_idx),   32'h0A);
        chk("bp_hold2_valid", 32'(stream_if.out_valid), 32'd1);
        chk("bp_hold2_last",  32'(stream_if.out_last),  32'd0);
        stream_if.in_ready = 1'b1;
        step();
        chk("bp_b2", 32'(stream_if.out_idx), 32'h11);
        step();
        chk("bp_b3",      32'(stream_if.out_idx),  32'h20);
        chk("bp_b3_last", 32'(stream_if.out_last), 32'd1);
        step();
        chk("bp_end_valid", 32'(stream_if.out_valid), 32'd0);

        // Partial frame.
        in_valid_count = 3'd2;
        pulse_frame();
        expect_beats("partial", arr_a, 2);

        // Empty frame: nothing streams, nothing counted.
        in_valid_count = 3'd0;
        pulse_frame();
        chk("empty_valid", 32'(stream_if.out_valid), 32'd0);
        chk("empty_busy",  32'(out_busy),            32'd0);
        step();
        chk("empty_valid2", 32'(stream_if.out_valid), 32'd0);
        chk("empty_drop",   32'(out_drop_cnt),        32'd0);

        // Oversized count clamps to the array depth.
        in_valid_count = 3'd7;
        pulse_frame();
        expect_beats("clamp", arr_a, 4);

        // Two frame_done pulses mid-stream are dropped.
        in_valid_count = 3'd4;
        pulse_frame();
        chk("drop_b0", 32'(stream_if.out_idx), 32'h03);
        step();
        chk("drop_b1", 32'(stream_if.out_idx), 32'h0A);
        in_smallest_idx = arr_junk;
        in_frame_done   = 1'b1;
        step();
        chk("drop_b2", 32'(stream_if.out_idx), 32'h11);
        step();
        in_frame_done = 1'b0;
        chk("drop_b3",      32'(stream_if.out_idx),  32'h20);
        chk("drop_b3_last", 32'(stream_if.out_last), 32'd1);
        step();
        chk("drop_end_valid", 32'(stream_if.out_valid), 32'd0);
        chk("drop_cnt2",      32'(out_drop_cnt),        32'd2);

        // Back-to-back frame on the last-beat handshake edge.
        in_smallest_idx = arr_a;
        in_valid_count  = 3'd4;
        pulse_frame();
        repeat (3) step();
        chk("b2b_last_idx", 32'(stream_if.out_idx),  32'h20);
        chk("b2b_last",     32'(stream_if.out_last), 32'd1);
        in_smallest_idx = arr_b;
        in_valid_count  = 3'd2;
        pulse_frame();
        chk("b2b_valid", 32'(stream_if.out_valid), 32'd1);
        chk("b2b_idx0",  32'(stream_if.out_idx),   32'h55);
        chk("b2b_last0", 32'(stream_if.out_last),  32'd0);
        chk("b2b_drop",  32'(out_drop_cnt),        32'd2);
        step();
        chk("b2b_idx1",  32'(stream_if.out_idx),  32'h66);
        chk("b2b_last1", 32'(stream_if.out_last), 32'd1);
        step();
        chk("b2b_end_valid", 32'(stream_if.out_valid), 32'd0);

        // Drop counter saturates while the stream is stalled.
        in_smallest_idx = arr_a;
        in_valid_count  = 3'd4;
        pulse_frame();
        stream_if.in_ready = 1'b0;
        in_smallest_idx    = arr_junk;
        for (int i = 0; i < 300; i++) begin
            in_frame_done = 1'b1;
            step();
        end
        in_frame_done = 1'b0;
        chk("sat_drop", 32'(out_drop_cnt), 32'hFF);
        stream_if.in_ready = 1'b1;
        expect_beats("sat", arr_a, 4);

        // Asynchronous reset during beat 2.
        in_smallest_idx = arr_a;
        pulse_frame();
        step();
        chk("arst_pre_idx", 32'(stream_if.out_idx), 32'h0A);
        #2;
        in_rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(stream_if.out_valid), 32'd0);
        chk("arst_busy",  32'(out_busy),            32'd0);
        chk("arst_last",  32'(stream_if.out_last),  32'd0);
        chk("arst_drop",  32'(out_drop_cnt),        32'd0);
        step();
        in_rst_n = 1'b1;
        step();
        chk("arst_idle_valid", 32'(stream_if.out_valid), 32'd0);
        pulse_frame();
        expect_beats("post_rst", arr_a, 4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
